// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: word type, 2-bit direction counter encodings,
// the default-geometry BTB entry layout, and a sequential-PC helper.
package branch_predictor_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_ctr_t;

  // Entry layout for the default 16-entry, 2-bit-counter build.
  localparam int unsigned BtbIdxW = 4;
  localparam int unsigned BtbTagW = 32 - BtbIdxW - 2;

  typedef struct packed {
    logic               valid;
    logic [BtbTagW-1:0] tag;
    word_t              target;
    bp_ctr_t            ctr;
    logic               jmp;
  } btb_entry_t;

  function automatic word_t pc_plus4(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational next-value of a saturating up/down counter; set_max_i has priority.
module branch_predictor_sat_counter #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] cnt_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             set_max_i,
  output logic [CTR_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (set_max_i) begin
      cnt_o = '1;
    end else if (inc_i && (cnt_i != '1)) begin
      cnt_o = cnt_i + CTR_W'(1);
    end else if (dec_i && (cnt_i != '0)) begin
      cnt_o = cnt_i - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and EX mispredict detection.
// Optional BRANCH_PREDICTOR_STATS_EN adds saturating branch/mispredict statistics outputs.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned      ENTRIES   = 16,
  parameter int unsigned      CTR_W     = 2,
  parameter logic [CTR_W-1:0] ALLOC_CTR = CTR_W'(2'b10)
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t lookup_pc,
  output logic  pred_taken,
  output word_t pred_target,
  input  logic  update_en,
  input  word_t update_pc,
  input  logic  update_is_jump,
  input  logic  update_taken,
  input  word_t update_target,
  input  logic  update_pred_taken,
  input  word_t update_pred_target,
  input  logic  invalidate,
  output logic  mispredict,
  output word_t correct_pc
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned IdxW = $clog2(ENTRIES);
  localparam int unsigned TagW = 32 - IdxW - 2;
  localparam logic [CTR_W-1:0] CtrRst = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] jmp_q, jmp_d;
  logic [TagW-1:0]    tag_q    [ENTRIES];
  logic [TagW-1:0]    tag_d    [ENTRIES];
  word_t              target_q [ENTRIES];
  word_t              target_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [CTR_W-1:0]   ctr_d    [ENTRIES];

  logic [IdxW-1:0]  l_idx, u_idx;
  logic [TagW-1:0]  l_tag, u_tag;
  logic             l_hit, u_hit;
  logic [CTR_W-1:0] ctr_nxt;

  assign l_idx = lookup_pc[IdxW+1:2];
  assign l_tag = lookup_pc[31:IdxW+2];
  assign u_idx = update_pc[IdxW+1:2];
  assign u_tag = update_pc[31:IdxW+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Lookup reads registered state only, so a same-cycle update is never forwarded.
  assign pred_taken  = l_hit && (jmp_q[l_idx] || ctr_q[l_idx][CTR_W-1]);
  assign pred_target = pred_taken ? target_q[l_idx] : pc_plus4(lookup_pc);

  assign mispredict = update_en && ((update_taken != update_pred_taken) ||
                                    (update_taken && (update_target != update_pred_target)));
  assign correct_pc = update_taken ? update_target : pc_plus4(update_pc);

  branch_predictor_sat_counter #(
    .CTR_W(CTR_W)
  ) u_sat_counter (
    .cnt_i    (ctr_q[u_idx]),
    .inc_i    (update_taken),
    .dec_i    (!update_taken),
    .set_max_i(update_is_jump),
    .cnt_o    (ctr_nxt)
  );

  always_comb begin
    valid_d  = valid_q;
    jmp_d    = jmp_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (invalidate) begin
      valid_d = '0;
    end else if (update_en) begin
      if (u_hit) begin
        ctr_d[u_idx] = ctr_nxt;
        if (update_is_jump) begin
          jmp_d[u_idx]    = 1'b1;
          target_d[u_idx] = update_target;
        end else if (update_taken) begin
          target_d[u_idx] = update_target;
        end
      end else if (update_taken) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = update_target;
        jmp_d[u_idx]    = update_is_jump;
        ctr_d[u_idx]    = update_is_jump ? '1 : ALLOC_CTR;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_q <= '0;
      jmp_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CtrRst;
      end
    end else begin
      valid_q  <= valid_d;
      jmp_q    <= jmp_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (invalidate) begin
      stat_br_d = '0;
      stat_mp_d = '0;
    end else begin
      if (update_en && (stat_br_q != '1)) stat_br_d = stat_br_q + 32'd1;
      if (mispredict && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic  CLK, nRST;
  word_t lookup_pc, pred_target, update_pc, update_target, update_pred_target, correct_pc;
  logic  pred_taken, update_en, update_is_jump, update_taken, update_pred_taken;
  logic  invalidate, mispredict;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  branch_predictor dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .lookup_pc         (lookup_pc),
    .pred_taken        (pred_taken),
    .pred_target       (pred_target),
    .update_en         (update_en),
    .update_pc         (update_pc),
    .update_is_jump    (update_is_jump),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_pred_taken (update_pred_taken),
    .update_pred_target(update_pred_target),
    .invalidate        (invalidate),
    .mispredict        (mispredict),
    .correct_pc        (correct_pc)
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    .stat_branches     (stat_branches),
    .stat_mispredicts  (stat_mispredicts)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd(input word_t pc, input logic jmp, input logic tkn, input word_t tgt,
                     input logic ptkn, input word_t ptgt);
    update_en          = 1'b1;
    update_pc          = pc;
    update_is_jump     = jmp;
    update_taken       = tkn;
    update_target      = tgt;
    update_pred_taken  = ptkn;
    update_pred_target = ptgt;
  endtask

  task automatic idle();
    update_en  = 1'b0;
    invalidate = 1'b0;
  endtask

  task automatic look(input string tag, input word_t pc, input logic exp_tkn,
                      input word_t exp_tgt);
    lookup_pc = pc;
    #1;
    check_eq({tag, "_taken"}, 32'(pred_taken), 32'(exp_tkn));
    check_eq({tag, "_target"}, pred_target, exp_tgt);
  endtask

  task automatic mp(input string tag, input logic exp_mp, input word_t exp_pc);
    #1;
    check_eq({tag, "_mp"}, 32'(mispredict), 32'(exp_mp));
    check_eq({tag, "_cpc"}, correct_pc, exp_pc);
  endtask

  initial begin
    nRST = 1'b0;
    lookup_pc = '0;
    upd('0, 1'b0, 1'b0, '0, 1'b0, '0);
    idle();
    tick();
    tick();
    nRST = 1'b1;

    look("rst", 32'h40, 1'b0, 32'h44);
    #1 check_eq("rst_mp", 32'(mispredict), 32'd0);
`ifdef BRANCH_PREDICTOR_STATS_EN
    check_eq("rst_stat_br", stat_branches, 32'd0);
`endif

    // Allocate; same-cycle lookup must still see the empty entry.
    upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    mp("alloc", 1'b1, 32'h100);
    look("alloc_same", 32'h40, 1'b0, 32'h44);
    tick();
    idle();
    look("alloc_next", 32'h40, 1'b1, 32'h100);

    // 10 -> 01 -> 00 -> 00
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    mp("nt1", 1'b1, 32'h44);
    tick();
    idle();
    look("nt1", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44);
    mp("nt2", 1'b0, 32'h44);
    tick();
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44);
    tick();
    // 00 -> 01 -> 10: only saturation at 00 makes the second taken predict taken.
    upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    tick();
    idle();
    look("t1", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    tick();
    idle();
    look("t2", 32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b1, 32'h100);
    mp("t_ok", 1'b0, 32'h100);
    tick();
    tick();
    // Counter should be held at 11, so one not-taken leaves it at 10.
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    tick();
    idle();
    look("sat_hi", 32'h40, 1'b1, 32'h100);

    // Aliasing on index 0
    upd(32'h80, 1'b0, 1'b1, 32'h180, 1'b0, 32'h84);
    tick();
    idle();
    look("alias_old", 32'h40, 1'b0, 32'h44);
    look("alias_new", 32'h80, 1'b1, 32'h180);

    // JR with changing target
    upd(32'h204, 1'b1, 1'b1, 32'h300, 1'b0, 32'h208);
    tick();
    idle();
    look("jr1", 32'h204, 1'b1, 32'h300);
    upd(32'h204, 1'b1, 1'b1, 32'h340, 1'b1, 32'h300);
    mp("jr2", 1'b1, 32'h340);
    tick();
    idle();
    look("jr2", 32'h204, 1'b1, 32'h340);
    upd(32'h204, 1'b1, 1'b1, 32'h400, 1'b1, 32'h340);
    look("jr_same", 32'h204, 1'b1, 32'h340);
    tick();
    idle();
    look("jr3", 32'h204, 1'b1, 32'h400);

    // Wrap of pc+4
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    upd(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234);
    mp("wrap", 1'b1, 32'h0);
    tick();
    idle();

    // Invalidate beats a simultaneous allocation
    upd(32'h44, 1'b0, 1'b1, 32'h500, 1'b0, 32'h48);
    invalidate = 1'b1;
    tick();
    idle();
    look("inv_upd", 32'h44, 1'b0, 32'h48);
    look("inv_old", 32'h204, 1'b0, 32'h208);
`ifdef BRANCH_PREDICTOR_STATS_EN
    check_eq("inv_stat_br", stat_branches, 32'd0);
    check_eq("inv_stat_mp", stat_mispredicts, 32'd0);
    upd(32'h44, 1'b0, 1'b1, 32'h500, 1'b0, 32'h48);
    tick();
    idle();
    check_eq("stat_br1", stat_branches, 32'd1);
    check_eq("stat_mp1", stat_mispredicts, 32'd1);
`endif

    // Synchronous reset mid-operation clears the table despite update_en
    upd(32'h88, 1'b0, 1'b1, 32'h600, 1'b0, 32'h8C);
    tick();
    upd(32'h88, 1'b0, 1'b1, 32'h700, 1'b1, 32'h600);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    idle();
    look("rst_mid", 32'h88, 1'b0, 32'h8C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
